// File: rtl/iir_pkg.sv
// Shared constants and types for the IIR coefficient loader.
package iir_pkg;

  // IEEE-754 double 1.0, the reset value of b0 (unity pass-through).
  localparam logic [63:0] FP_ONE = 64'h3FF0_0000_0000_0000;

  // Coefficient order within a frame and within the shadow bank.
  localparam logic [2:0] C_B0 = 3'd0;
  localparam logic [2:0] C_B1 = 3'd1;
  localparam logic [2:0] C_B2 = 3'd2;
  localparam logic [2:0] C_A1 = 3'd3;
  localparam logic [2:0] C_A2 = 3'd4;
  localparam int         NUM_COEF = 5;

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PENDING = 2'd2
  } state_t;

endpackage

// File: rtl/iir_coef_loader_coef_bank.sv
// Shadow register file for one coefficient frame plus the active set that
// the filter reads. The active set changes only on a commit, all at once.
module coef_bank
  import iir_pkg::*;
#(
  parameter int DW       = 16,
  parameter bit NEGATE_A = 1'b1,
  parameter int IW       = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [IW-1:0] i_idx,
  input  logic [DW-1:0] i_data,
  input  logic          i_commit,
  output logic [63:0]   o_b0,
  output logic [63:0]   o_b1,
  output logic [63:0]   o_b2,
  output logic [63:0]   o_a1,
  output logic [63:0]   o_a2
);

  localparam int WPC = 64 / DW;
  localparam int SW  = (WPC > 1) ? $clog2(WPC) : 1;

  // Sign mask applied to a1/a2 when the filter expects negated feedback terms.
  localparam logic [63:0] A_MASK = {NEGATE_A, 63'd0};

  logic [63:0]   r_shadow [NUM_COEF];
  logic [2:0]    w_sel;
  logic [SW-1:0] w_slot;
  logic [63:0]   r_b0, r_b1, r_b2, r_a1, r_a2;

  // Decode the frame word index into coefficient select and word slot (MS word first).
  always_comb begin
    w_sel  = 3'(i_idx / IW'(WPC));
    w_slot = SW'(WPC - 1) - SW'(i_idx % IW'(WPC));
  end

  // Shadow bank write port, one DW-wide slot per accepted word.
  // NOTE: the shadow bank has no reset; a commit only happens after a full
  // frame has rewritten every slot, so stale contents can never become active.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_shadow[w_sel][w_slot*DW +: DW] <= i_data;
    end
  end

  // Active coefficient set: reset to unity, replaced as a whole on commit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_b0 <= FP_ONE;
      r_b1 <= '0;
      r_b2 <= '0;
      r_a1 <= '0;
      r_a2 <= '0;
    end else if (i_commit) begin
      r_b0 <= r_shadow[C_B0];
      r_b1 <= r_shadow[C_B1];
      r_b2 <= r_shadow[C_B2];
      r_a1 <= r_shadow[C_A1] ^ A_MASK;
      r_a2 <= r_shadow[C_A2] ^ A_MASK;
    end
  end

  assign o_b0 = r_b0;
  assign o_b1 = r_b1;
  assign o_b2 = r_b2;
  assign o_a1 = r_a1;
  assign o_a2 = r_a2;

endmodule

// File: rtl/iir_coef_loader.sv
// Coefficient frame loader for the 2-stage DF-I floating-point IIR filter.
// Assembles b0,b1,b2,a1,a2 from a narrow word stream into a shadow bank and
// commits the whole set on the next sample-rate enable.
module iir_coef_loader
  import iir_pkg::*;
#(
  parameter int DW       = 16,
  parameter bit NEGATE_A = 1'b1
) (
  input  logic          clk_fast,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_first,
  input  logic          sample_en,
  output logic [63:0]   b0,
  output logic [63:0]   b1,
  output logic [63:0]   b2,
  output logic [63:0]   a1,
  output logic [63:0]   a2,
  output logic          coef_update,
  output logic          frame_err,
  output logic          busy
);

  localparam int WPC    = 64 / DW;
  localparam int NWORDS = NUM_COEF * WPC;
  localparam int IW     = $clog2(NWORDS);

  state_t        r_state, w_next;
  logic [IW-1:0] r_idx, w_idx_next, w_widx;
  logic          r_wr_ready, r_coef_update, r_frame_err;
  logic          w_xfer, w_we, w_err, w_commit;

  assign w_xfer = wr_valid & r_wr_ready;

  // Next-state, word counter and bank-control decode for the loader FSM.
  // NOTE: every signal gets a default before the case so no path can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    w_widx     = r_idx;
    w_we       = 1'b0;
    w_err      = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (wr_first) begin
            w_we       = 1'b1;
            w_widx     = '0;
            w_idx_next = IW'(1);
            w_next     = LOAD;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      LOAD: begin
        if (w_xfer) begin
          w_we = 1'b1;
          if (wr_first) begin
            // Restart: this word is word 0 of a fresh frame.
            w_widx     = '0;
            w_idx_next = IW'(1);
            w_err      = 1'b1;
          end else if (r_idx == IW'(NWORDS - 1)) begin
            w_idx_next = '0;
            w_next     = PENDING;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      PENDING: begin
        if (sample_en) begin
          w_commit = 1'b1;
          w_next   = IDLE;
        end
      end
      default: begin
        w_next     = IDLE;
        w_idx_next = '0;
      end
    endcase
  end

  // State, counter and registered handshake/status pulses.
  // NOTE: non-blocking assignments so every register samples the pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_wr_ready    <= 1'b0;
      r_coef_update <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_idx         <= w_idx_next;
      r_wr_ready    <= (w_next != PENDING);
      r_coef_update <= w_commit;
      r_frame_err   <= w_err;
    end
  end

  coef_bank #(
    .DW       (DW),
    .NEGATE_A (NEGATE_A),
    .IW       (IW)
  ) u_coef_bank (
    .i_clk    (clk_fast),
    .i_rst    (rst),
    .i_we     (w_we),
    .i_idx    (w_widx),
    .i_data   (wr_data),
    .i_commit (w_commit),
    .o_b0     (b0),
    .o_b1     (b1),
    .o_b2     (b2),
    .o_a1     (a1),
    .o_a2     (a2)
  );

  assign wr_ready    = r_wr_ready;
  assign coef_update = r_coef_update;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != IDLE);

endmodule

// File: doc/iir_coef_loader.md
# iir_coef_loader

Coefficient writer for the 2-stage direct-form-I floating-point IIR filter. It accepts a coefficient frame as a stream of narrow words from the control side, assembles b0, b1, b2, a1 and a2 as 64-bit doubles in a shadow bank, and applies the sign inversion of a1/a2 that the filter requires. It then commits the whole set atomically on a sample-rate enable pulse, so the filter never computes with a mixed old/new coefficient set.

## Interface
Parameters:
- DW, 16, input word width; must divide 64; words per coefficient WPC = 64/DW.
- NEGATE_A, 1, when 1 the sign bit (bit 63) of a1 and a2 is inverted at commit.

Ports:
- clk_fast  in  1  single clock for all logic.
- rst  in  1  reset, asynchronous and active-high.
- wr_valid  in  1  word valid.
- wr_ready  out  1  loader can accept a word.
- wr_data  in  DW  coefficient word; most-significant word first.
- wr_first  in  1  marks word 0 of a frame.
- sample_en  in  1  one-cycle sample-rate enable, the same pulse that clocks the filter's delay registers.
- b0, b1, b2, a1, a2  out  64 each  active coefficient set, IEEE double.
- coef_update  out  1  one-cycle pulse when a new set becomes active.
- frame_err  out  1  one-cycle pulse on a framing error.
- busy  out  1  high when a frame is partially loaded or a commit is pending.

## Operation
- Frame order: b0, b1, b2, a1, a2, each as WPC words from MS to LS. One frame is 5·WPC words (20 at DW=16).
- A word transfers on a cycle where wr_valid and wr_ready are both high.
- Word counter idx is 0..5·WPC−1. Coefficient select is idx/WPC. Slot is WPC−1−(idx mod WPC).
- States:
  - IDLE: wr_ready=1. A transfer with wr_first=1 stores word 0, sets idx=1 and moves to LOAD. A transfer with wr_first=0 is discarded and pulses frame_err.
  - LOAD: wr_ready=1. Each transfer with wr_first=0 stores the word at idx and increments idx. A transfer with wr_first=1 restarts the frame: it stores word 0, sets idx=1 and pulses frame_err. When the final word transfers, the state moves to PENDING.
  - PENDING: wr_ready=0; the shadow bank is frozen. On the first cycle with sample_en=1, the shadow bank is copied to the outputs, with a1/a2 bit 63 inverted if NEGATE_A=1. coef_update pulses and the state returns to IDLE.
- The active outputs change only at commit. They are never partially updated.
- busy = (state != IDLE).
- Reset values:
  - b0 = 64'h3FF0_0000_0000_0000 (1.0); b1 = b2 = a1 = a2 = 0, giving unity pass-through.
  - wr_ready=0 during reset, 1 in the first cycle after reset release.
  - coef_update=0, frame_err=0, busy=0.
  - State is IDLE and idx=0.
- Reset mid-frame or in PENDING discards the shadow bank. The active set returns to the reset values.

## Timing
- All outputs are registered.
- Final word transfers at cycle t. State is PENDING from t+1.
- A sample_en high at cycle t (the same cycle as the final word) does not commit.
- The earliest commit uses sample_en at t+1. The new coefficients and coef_update are visible at t+2.
- Commit latency is 1 cycle from the sample_en edge. coef_update is coincident with the new output values.
- frame_err is asserted in the cycle after the offending transfer, for exactly 1 cycle.
- wr_ready drops in the cycle after the final word. A word offered in PENDING is held by the sender and not lost.
- sample_en in IDLE or LOAD has no effect.
- Back-to-back frames are supported: a frame may begin in the cycle after coef_update. Throughput is 1 word per cycle.

## Structure
- Shared package iir_pkg:
  - FP_ONE = 64'h3FF0_0000_0000_0000.
  - Coefficient index constants C_B0..C_A2 = 0..4.
  - The state encoding (IDLE, LOAD, PENDING).
- One sub-module, coef_bank: a 5×64 shadow register file with a word-slot write port, plus the commit copy and sign-inversion logic.
- The loader FSM and the counter stay in the top module.
- Output registers use the existing register module only if it supports an asynchronous active-high reset; otherwise they are plain always blocks.

## Test plan
- Reset check: assert rst, release -> b0=64'h3FF0000000000000, others 0, wr_ready=1, busy=0, coef_update=0.
- Nominal load:
  - Stimulus: 20 words (b0=1.0, b1=2.0, b2=1.0, a1=−1.5, a2=0.5), then sample_en 5 cycles later.
  - Required response: outputs 3FF0…, 4000…, 3FF0…, a1=3FF8… (+1.5), a2=BFE0… (−0.5); coef_update pulses once.
- Same-cycle case: sample_en coincident with the final word -> no commit. A second sample_en commits with 1-cycle latency. The outputs hold their old values throughout.
- Restart: wr_first asserted at word 7 -> frame_err pulses once. The following 20 words form the frame. Committed values match that second frame only.
- Backpressure: words offered continuously while PENDING -> wr_ready=0, no shadow change. After commit, the pending word is accepted as the next frame's word 0.
- Async reset in PENDING -> outputs return to unity immediately with no clock edge; no coef_update pulse.
